// File: rtl/imem_stream_loader_pkg.sv
// Shared types and constants for the instruction-memory stream loader.
package imem_loader_pkg;

  localparam int BYTES_PER_WORD = 8;
  localparam int LEN_BYTES      = 2;

  typedef enum logic [2:0] {
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_WRITE,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } loader_state_t;

endpackage

// File: rtl/imem_stream_loader_word_assembler.sv
// Little-endian byte-to-word shift buffer. The first byte shifted in ends up
// in bits [7:0] once a full word has been collected.
module word_assembler
  import imem_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  shift_en_i,
  input  logic [7:0]            byte_i,
  input  logic                  idx_clr_i,
  output logic [DATA_WIDTH-1:0] word_next_o,
  output logic                  word_full_o
);

  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [2:0]            idx_q, idx_d;

  // word_next_o is the word as it will look once byte_i is shifted in, so the
  // parent can capture a completed word on the same edge as its last byte.
  assign word_next_o = {byte_i, shreg_q[DATA_WIDTH-1:8]};

  // High while the next accepted byte is the last one of the current word.
  assign word_full_o = (idx_q == 3'(BYTES_PER_WORD - 1));

  // Next-state for the shift register and byte index; clear wins over shift.
  always_comb begin
    shreg_d = shreg_q;
    idx_d   = idx_q;
    if (idx_clr_i) begin
      idx_d = '0;
    end else if (shift_en_i) begin
      shreg_d = word_next_o;
      idx_d   = idx_q + 3'd1;
    end
  end

  // Buffer and index registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      shreg_q <= '0;
      idx_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: rtl/imem_stream_loader.sv
// Boot-time loader: receives a length-prefixed, XOR-checksummed byte stream,
// writes 64-bit words into instruction memory and releases the CPU only when
// the whole image has been verified.
//
// state     | meaning
// ----------+------------------------------------------------------
// LEN_LO    | waiting for low byte of word count
// LEN_HI    | waiting for high byte of word count; range check
// DATA      | collecting bytes of the current word
// WRITE     | one-cycle memory write of the assembled word
// CHECK     | waiting for checksum byte
// DONE      | image verified, CPU released (absorbing)
// ERROR     | length or checksum failure, CPU held (absorbing)
module imem_stream_loader
  import imem_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_WORDS  = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam int LW = (CW > 16) ? CW : 16;

  loader_state_t         state_q, state_d;
  logic [7:0]            len_lo_q, len_lo_d;
  logic [15:0]           len_q, len_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            csum_q, csum_d;
  logic [ADDR_WIDTH:0]   words_q, words_d;
  logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
  logic [DATA_WIDTH-1:0] imem_wdata_q, imem_wdata_d;

  logic                  accept;
  logic [15:0]           len_full;
  logic                  oversize;
  logic                  last_word;
  logic                  shift_en;
  logic                  idx_clr;
  logic [DATA_WIDTH-1:0] word_next;
  logic                  word_full;

  word_assembler #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_word_assembler (
    .clk         (clk),
    .reset       (reset),
    .shift_en_i  (shift_en),
    .byte_i      (rx_data),
    .idx_clr_i   (idx_clr),
    .word_next_o (word_next),
    .word_full_o (word_full)
  );

  assign accept    = rx_valid & rx_ready;
  assign len_full  = {rx_data, len_lo_q};
  assign oversize  = ({1'b0, len_full} > 17'(MAX_WORDS));
  assign last_word = ((LW'(words_q) + LW'(1)) == LW'(len_q));

  assign imem_addr    = imem_addr_q;
  assign imem_wdata   = imem_wdata_q;
  assign words_loaded = words_q;
  assign imem_we      = (state_q == ST_WRITE);
  assign cpu_hold     = (state_q != ST_DONE);
  assign load_done    = (state_q == ST_DONE);
  assign load_error   = (state_q == ST_ERROR);

  // Next-state, datapath updates and ready decode; rx_ready depends on state only.
  always_comb begin
    state_d      = state_q;
    len_lo_d     = len_lo_q;
    len_d        = len_q;
    addr_d       = addr_q;
    csum_d       = csum_q;
    words_d      = words_q;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    shift_en     = 1'b0;
    idx_clr      = 1'b0;
    rx_ready     = 1'b0;

    case (state_q)
      ST_LEN_LO: begin
        rx_ready = 1'b1;
        if (accept) begin
          len_lo_d = rx_data;
          state_d  = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        rx_ready = 1'b1;
        if (accept) begin
          len_d = len_full;
          if (oversize)             state_d = ST_ERROR;
          else if (len_full == '0)  state_d = ST_CHECK;
          else                      state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        rx_ready = 1'b1;
        if (accept) begin
          shift_en = 1'b1;
          csum_d   = csum_q ^ rx_data;
          if (word_full) begin
            // Capture address and word here so both are stable for the whole
            // write cycle and hold afterwards while the counter moves on.
            imem_wdata_d = word_next;
            imem_addr_d  = addr_q;
            state_d      = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        addr_d  = addr_q + ADDR_WIDTH'(1);
        words_d = words_q + CW'(1);
        idx_clr = 1'b1;
        state_d = last_word ? ST_CHECK : ST_DATA;
      end
      ST_CHECK: begin
        rx_ready = 1'b1;
        if (accept) begin
          state_d = (rx_data == csum_q) ? ST_DONE : ST_ERROR;
        end
      end
      ST_DONE:  state_d = ST_DONE;
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_ERROR;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_LEN_LO;
      len_lo_q     <= '0;
      len_q        <= '0;
      addr_q       <= '0;
      csum_q       <= '0;
      words_q      <= '0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      len_lo_q     <= len_lo_d;
      len_q        <= len_d;
      addr_q       <= addr_d;
      csum_q       <= csum_d;
      words_q      <= words_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
    end
  end

endmodule

// File: doc/imem_stream_loader.md
Name: imem_stream_loader

Overview:
- Boot-time writer for the TessiaX64 instruction memory.
- Receives a program image as a byte stream over a valid/ready handshake and assembles 64-bit instruction words. Writes them sequentially into the instruction memory's write port.
- Holds the CPU (`cpu_hold`) until a length-checked, checksum-verified image is fully loaded.
- Sits between the host byte link and the instruction memory/CPU reset logic.

Parameters:
- `DATA_WIDTH`, 64: instruction word width in bits; fixed at 8 bytes per word.
- `ADDR_WIDTH`, 10: instruction memory word-address width.
- `MAX_WORDS`, 1024: largest accepted image length in words; must be ≤ 2**`ADDR_WIDTH`.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-low reset. `reset`=0 sampled at a rising edge resets the block.
- `rx_data`  in  8  stream byte.
- `rx_valid`  in  1  `rx_data` valid.
- `rx_ready`  out  1  block accepts the byte this cycle.
- `imem_we`  out  1  instruction memory write strobe, one-cycle pulse.
- `imem_addr`  out  `ADDR_WIDTH`  word address of the write.
- `imem_wdata`  out  `DATA_WIDTH`  assembled word.
- `cpu_hold`  out  1  1 = keep the CPU in reset/stalled.
- `load_done`  out  1  image loaded and verified (sticky).
- `load_error`  out  1  length or checksum failure (sticky).
- `words_loaded`  out  `ADDR_WIDTH`+1  count of words written so far.

Behaviour:
- **Handshake.** A byte transfers on a rising edge with `rx_valid`=1 and `rx_ready`=1. `rx_ready` is combinational from state only; it never depends on `rx_valid`.
- **Stream format, little-endian throughout:**
  - `LEN_LO`, then `LEN_HI`: 16-bit word count N.
  - N×8 data bytes; the first byte of each word lands in bits [7:0].
  - One checksum byte equal to the XOR of all data bytes. Length bytes are not included.
- **States:** `LEN_LO`, `LEN_HI`, `DATA`, `WRITE`, `CHECK`, `DONE`, `ERROR`.
- **Reset.** While `reset`=0, at the clock edge:
  - state = `LEN_LO`; byte index, word address, checksum accumulator and `words_loaded` are all cleared.
  - `imem_we`=0, `imem_addr`=0, `imem_wdata`=0.
  - `cpu_hold`=1, `load_done`=0, `load_error`=0.
  - Reset in any state, including mid-word or mid-write, aborts the load. Partially written memory is not cleared.
- **`rx_ready`.** 1 in `LEN_LO`, `LEN_HI`, `DATA` and `CHECK`. 0 in `WRITE`, `DONE` and `ERROR`.
- **Transitions:**
  - `LEN_LO` → `LEN_HI` on accept.
  - `LEN_HI` on accept:
    - N > `MAX_WORDS` → `ERROR`.
    - N = 0 → `CHECK`.
    - Otherwise → `DATA`.
  - `DATA`: each accepted byte is shifted into the word buffer and XORed into the checksum. On the 8th byte of a word → `WRITE`.
  - `WRITE` (exactly one cycle):
    - `imem_we`=1, with `imem_addr` and `imem_wdata` valid in the same cycle.
    - Next cycle: address +1, `words_loaded` +1, byte index cleared.
    - Then → `CHECK` if this was word N, else → `DATA`.
  - `CHECK` on accept: byte equal to accumulator → `DONE`; mismatch → `ERROR`.
  - `DONE`: `cpu_hold`=0, `load_done`=1. Absorbing until reset.
  - `ERROR`: `cpu_hold`=1, `load_error`=1. Absorbing until reset.
- **Latency.** `imem_we` rises the cycle after the 8th byte of a word is accepted. `cpu_hold` falls the cycle after a good checksum is accepted.
- **Output timing.** `imem_we`=0 in every state except `WRITE`. `imem_addr` and `imem_wdata` hold their last values outside `WRITE`.
- **Boundaries:**
  - `rx_valid` gaps in any state simply stall the FSM; no timeout.
  - N = `MAX_WORDS` is legal; the final address is `MAX_WORDS`-1 and never wraps.
  - Bytes offered in `DONE`/`ERROR` are not accepted.
  - `load_done` and `load_error` are never both 1.

Decomposition:
- Shared package `imem_loader_pkg`:
  - `loader_state_t` enum.
  - `BYTES_PER_WORD`=8.
  - `LEN_BYTES`=2.
- Sub-module `word_assembler`: 8-bit → 64-bit little-endian shift buffer with a 3-bit byte index, a `word_full` flag and an index clear. The FSM, address counter and checksum stay in the top level.

Test Plan:
1. Two-word image, stream `02 00 88 77 66 55 44 33 22 11 01 00 00 00 00 00 00 00 89`, `rx_valid` held 1:
   - `imem_we` pulses twice: addr 0 ← 0x1122334455667788, addr 1 ← 0x0000000000000001.
   - `rx_ready`=0 during each write cycle.
   - `load_done`=1, `cpu_hold`=0, `words_loaded`=2.
2. Zero-length image `00 00 00` → no `imem_we`, `load_done`=1. Separately, `00 00 5A` → `load_error`=1, `cpu_hold`=1.
3. Oversize length `01 04` (N=1025, `MAX_WORDS`=1024) → `ERROR` immediately after the 2nd byte, `rx_ready`=0, no writes.
4. Scenario 1 with checksum byte 0x88 → both words written, `load_error`=1, `load_done`=0, `cpu_hold` stays 1.
5. Scenario 1 with `rx_valid` randomly deasserted about 50% of cycles → identical memory contents and final flags; no byte lost or duplicated.
6. Drive `reset`=0 for one cycle after the 5th data byte, then replay scenario 1 in full → all outputs return to reset values, then the correct final result; addr 0 is rewritten from byte 0 of the new stream.
